// File: rtl/veririsc_pkg.sv
// Types and widths shared across the VeriRISC CPU: address type and the
// controller's stack operation encoding.
package veririsc_pkg;
   timeunit 1ns;
   timeprecision 100ps;

   localparam int ADDR_WIDTH = 5;

   typedef logic [ADDR_WIDTH-1:0] addr_t;

   typedef enum logic [1:0] {
      OP_NONE,
      OP_PUSH,
      OP_POP,
      OP_SWAP
   } stack_op_e;
endpackage

// File: rtl/stack_regfile.sv
// Write-indexed register array holding the saved return addresses, with a
// single asynchronous read port for the current top entry.
module stack_regfile #(
   parameter int WIDTH = 5,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);
   timeunit 1ns;
   timeprecision 100ps;

   logic [WIDTH-1:0] mem_q [DEPTH];

   // NOTE: no reset on the array; entries above sp are never observed, so
   // clearing them would only add reset fan-out.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];
endmodule

// File: rtl/pc_stack.sv
// Return-address stack: owns the stack pointer, sticky error flags and the
// push/pop guards; storage lives in stack_regfile.
module pc_stack
   import veririsc_pkg::*;
#(
   parameter  int WIDTH = ADDR_WIDTH,
   parameter  int DEPTH = 4,
   localparam int LW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] top,
   output logic [LW-1:0]    level,
   output logic             empty,
   output logic             full,
   output logic             overflow,
   output logic             underflow
);
   timeunit 1ns;
   timeprecision 100ps;

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   stack_op_e        op;
   logic [LW-1:0]    sp_q, sp_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;
   logic             we;
   logic [AW-1:0]    waddr;
   logic [AW-1:0]    top_idx;
   logic [WIDTH-1:0] rd_data;

   assign empty   = (sp_q == '0);
   assign full    = (sp_q == LW'(DEPTH));
   assign top_idx = AW'(sp_q - LW'(1));

   always_comb begin
      unique case ({push, pop})
         2'b00: op = OP_NONE;
         2'b10: op = OP_PUSH;
         2'b01: op = OP_POP;
         2'b11: op = OP_SWAP;
      endcase
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      sp_d        = sp_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      we          = 1'b0;
      waddr       = top_idx;
      if (clr) begin
         sp_d        = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         case (op)
            OP_PUSH: begin
               if (full) begin
                  overflow_d = 1'b1;
               end else begin
                  we    = 1'b1;
                  waddr = AW'(sp_q);
                  sp_d  = sp_q + LW'(1);
               end
            end
            OP_POP: begin
               if (empty) underflow_d = 1'b1;
               else       sp_d        = sp_q - LW'(1);
            end
            OP_SWAP: begin
               // Empty swap degenerates to a plain push that also flags the pop.
               we = 1'b1;
               if (empty) begin
                  waddr       = '0;
                  sp_d        = LW'(1);
                  underflow_d = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the values from before the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         sp_q        <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         sp_q        <= sp_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   stack_regfile #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_regfile (
      .clk   (clk),
      .we    (we && !rst),
      .waddr (waddr),
      .wdata (push_data),
      .raddr (top_idx),
      .rdata (rd_data)
   );

   assign top       = empty ? '0 : rd_data;
   assign level     = sp_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;
endmodule

// File: tb/tb_pc_stack.sv
// Self-checking bench for pc_stack: queue-based reference model compared every
// cycle, plus directed literal expectations.
module tb_pc_stack;
   timeunit 1ns;
   timeprecision 100ps;
   import veririsc_pkg::*;

   localparam int DEPTH = 4;
   localparam int LW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          clr = 1'b0;
   logic          push = 1'b0;
   logic          pop = 1'b0;
   addr_t         push_data = '0;
   addr_t         top;
   logic [LW-1:0] level;
   logic          empty, full, overflow, underflow;

   pc_stack #(.WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .push      (push),
      .pop       (pop),
      .push_data (push_data),
      .top       (top),
      .level     (level),
      .empty     (empty),
      .full      (full),
      .overflow  (overflow),
      .underflow (underflow)
   );

   always #5 clk = ~clk;

   int    checks = 0;
   int    errors = 0;
   bit    chk_en = 1'b0;
   addr_t stk[$];
   bit    m_ovf = 1'b0;
   bit    m_udf = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: stack as a queue, back of queue is the top entry.
   task automatic model_step(input bit r, input bit c, input bit pu, input bit po, input addr_t d);
      if (r || c) begin
         stk.delete();
         m_ovf = 1'b0;
         m_udf = 1'b0;
      end else if (pu && po) begin
         if (stk.size() == 0) begin
            stk.push_back(d);
            m_udf = 1'b1;
         end else begin
            stk[stk.size()-1] = d;
         end
      end else if (pu) begin
         if (stk.size() == DEPTH) m_ovf = 1'b1;
         else                     stk.push_back(d);
      end else if (po) begin
         if (stk.size() == 0) m_udf = 1'b1;
         else                 void'(stk.pop_back());
      end
   endtask

   // Apply one cycle of inputs, let the edge happen, then advance the model.
   task automatic drive(input bit r, input bit c, input bit pu, input bit po, input addr_t d);
      rst = r; clr = c; push = pu; pop = po; push_data = d;
      @(posedge clk);
      model_step(r, c, pu, po, d);
      #1;
      rst = 1'b0; clr = 1'b0; push = 1'b0; pop = 1'b0;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("cmp_level", 32'(level), 32'(stk.size()));
         check("cmp_top", 32'(top), (stk.size() == 0) ? 32'h0 : 32'(stk[stk.size()-1]));
         check("cmp_empty", 32'(empty), 32'(stk.size() == 0));
         check("cmp_full", 32'(full), 32'(stk.size() == DEPTH));
         check("cmp_overflow", 32'(overflow), 32'(m_ovf));
         check("cmp_underflow", 32'(underflow), 32'(m_udf));
      end
   end

   initial begin
      drive(1, 0, 0, 0, 5'h00);
      drive(1, 0, 0, 0, 5'h00);
      chk_en = 1'b1;
      repeat (3) drive(0, 0, 0, 0, 5'h00);
      check("rst_empty", 32'(empty), 32'h1);
      check("rst_level", 32'(level), 32'h0);
      check("rst_top", 32'(top), 32'h0);
      check("rst_flags", {30'h0, overflow, underflow}, 32'h0);

      drive(0, 0, 1, 0, 5'h03);
      check("push1_level", 32'(level), 32'h1);
      check("push1_top", 32'(top), 32'h03);
      drive(0, 0, 1, 0, 5'h0A);
      check("push2_top", 32'(top), 32'h0A);
      drive(0, 0, 1, 0, 5'h11);
      check("push3_top", 32'(top), 32'h11);
      drive(0, 0, 1, 0, 5'h1F);
      check("push4_level", 32'(level), 32'h4);
      check("push4_full", 32'(full), 32'h1);

      drive(0, 0, 1, 0, 5'h05);
      check("ovf_top", 32'(top), 32'h1F);
      check("ovf_level", 32'(level), 32'h4);
      check("ovf_flag", 32'(overflow), 32'h1);

      check("pop1_top", 32'(top), 32'h1F);
      drive(0, 0, 0, 1, 5'h00);
      check("pop2_top", 32'(top), 32'h11);
      drive(0, 0, 0, 1, 5'h00);
      check("pop3_top", 32'(top), 32'h0A);
      drive(0, 0, 0, 1, 5'h00);
      check("pop4_top", 32'(top), 32'h03);
      drive(0, 0, 0, 1, 5'h00);
      check("pops_empty", 32'(empty), 32'h1);
      check("ovf_sticky", 32'(overflow), 32'h1);

      drive(0, 1, 0, 0, 5'h00);
      check("clr_level", 32'(level), 32'h0);
      check("clr_ovf", 32'(overflow), 32'h0);

      drive(0, 0, 0, 1, 5'h00);
      check("udf_flag", 32'(underflow), 32'h1);
      check("udf_level", 32'(level), 32'h0);
      drive(0, 0, 1, 1, 5'h07);
      check("swap_empty_level", 32'(level), 32'h1);
      check("swap_empty_top", 32'(top), 32'h07);
      check("swap_empty_udf", 32'(underflow), 32'h1);

      drive(0, 1, 0, 0, 5'h00);
      drive(0, 0, 1, 0, 5'h03);
      drive(0, 0, 1, 0, 5'h0A);
      drive(0, 0, 1, 1, 5'h15);
      check("swap_level", 32'(level), 32'h2);
      check("swap_top", 32'(top), 32'h15);
      drive(0, 0, 0, 1, 5'h00);
      check("swap_pop_top", 32'(top), 32'h03);

      drive(0, 0, 1, 0, 5'h0A);
      drive(1, 0, 1, 0, 5'h09);
      check("midrst_level", 32'(level), 32'h0);
      check("midrst_empty", 32'(empty), 32'h1);
      drive(0, 0, 1, 0, 5'h04);
      check("post_rst_top", 32'(top), 32'h04);
      check("post_rst_level", 32'(level), 32'h1);

      drive(0, 1, 1, 0, 5'h1E);
      check("clr_push_level", 32'(level), 32'h0);

      for (int i = 0; i < 4; i++) drive(0, 0, 1, 0, addr_t'(i + 8));
      drive(0, 0, 1, 1, 5'h0C);
      check("swap_full_top", 32'(top), 32'h0C);
      check("swap_full_ovf", 32'(overflow), 32'h0);
      check("swap_full_level", 32'(level), 32'h4);

      drive(0, 1, 0, 0, 5'h00);
      for (int i = 0; i < 60; i++) begin
         drive(0, ($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom),
               addr_t'($urandom));
      end

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
